// File: rtl/seg_display_pkg.sv
// ---------------------------------------------------------------------------
// seg_display_pkg
// Shared types and constants for the seven-segment display arbiter.
//   state_t      : arbiter FSM states (IDLE, BLANK, SHOW)
//   NUM_REQ      : number of requesters sharing the display
//   NUM_DIG      : number of multiplexed digits on the board
//   SEG_W        : segments per digit pattern {g,f,e,d,c,b,a}
//   GLYPH_*      : active-high segment patterns for common characters
//   req_winner   : index of the highest asserted request bit
//   req_onehot   : one-hot grant vector for a requester index
//   rr_step      : next requester index in cyclic order
// ---------------------------------------------------------------------------
package seg_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int NUM_REQ = 3;
    localparam int NUM_DIG = 8;
    localparam int SEG_W   = 7;
    localparam int REQ_W   = 2;
    localparam int IDX_W   = 3;
    localparam int BUS_W   = NUM_DIG * SEG_W;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] GLYPH_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'b1100111;
    localparam logic [SEG_W-1:0] GLYPH_I     = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_D     = 7'b1011110;
    localparam logic [SEG_W-1:0] GLYPH_L     = 7'b0111000;
    localparam logic [SEG_W-1:0] BLANK_GLYPH = 7'b0000000;

    // Highest asserted index wins; returns 0 when nothing is requested,
    // callers qualify with req != 0.
    function automatic logic [REQ_W-1:0] req_winner(input logic [NUM_REQ-1:0] r);
        logic [REQ_W-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) begin
                w = REQ_W'(i);
            end
        end
        return w;
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [REQ_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == REQ_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [REQ_W-1:0] rr_step(input logic [REQ_W-1:0] cur);
        return (cur == REQ_W'(NUM_REQ - 1)) ? '0 : REQ_W'(cur + 1'b1);
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter_if
// Requester-side bundle of the display arbiter.
//   req   : per-requester display request, bit 2 highest priority
//   seg0..seg2 : 8-digit segment patterns per requester, digit k at [7k+6:7k]
//   gnt   : one-hot grant back to the requesters
//   busy  : arbiter is not idle
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface seg_display_arbiter_if;
    import seg_display_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [BUS_W-1:0]   seg0;
    logic [BUS_W-1:0]   seg1;
    logic [BUS_W-1:0]   seg2;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;

    modport master (
        output req, seg0, seg1, seg2,
        input  gnt, busy
    );

    modport slave (
        input  req, seg0, seg1, seg2,
        output gnt, busy
    );

endinterface

// File: rtl/seg_scan_timer.sv
// ---------------------------------------------------------------------------
// seg_scan_timer
// Digit-slot divider and digit index for the multiplexed display.
//   clk, rst   : clock, synchronous active-high reset
//   load_zero  : on a slot boundary, restart the digit index at 0
//                instead of advancing it
//   scan_tick  : one-cycle pulse on the last cycle of each slot
//   scan_idx   : current digit index 0..7, wraps 7 -> 0
// The divider free-runs regardless of load_zero so slot timing never
// depends on arbitration.
// ---------------------------------------------------------------------------
module seg_scan_timer
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_zero,
    output logic             scan_tick,
    output logic [IDX_W-1:0] scan_idx
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic [IDX_W-1:0] scan_idx_reg;
    logic [IDX_W-1:0] scan_idx_next;

    assign scan_tick = (div_cnt_reg == DIV_LAST);
    assign scan_idx  = scan_idx_reg;

    always_comb begin
        div_cnt_next  = DIV_W'(div_cnt_reg + 1'b1);
        scan_idx_next = scan_idx_reg;
        if (scan_tick) begin
            div_cnt_next  = '0;
            scan_idx_next = load_zero ? '0 : IDX_W'(scan_idx_reg + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            scan_idx_reg <= '0;
        end else begin
            div_cnt_reg  <= div_cnt_next;
            scan_idx_reg <= scan_idx_next;
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 8-digit multiplexed seven-segment display between three
// requesters (status panel, scrolling banner, alarm). Fixed-priority
// arbitration with a minimum hold time, a blanking slot on every ownership
// change, and direct drive of the board digit/segment pins.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : seg_display_arbiter_if.slave (req, seg0..2 in; gnt, busy out)
//   DIG      : digit enables, active-low
//   Y        : segments, active-low, Y[7] = dp held at 1
// Parameters:
//   SCAN_DIV : clk cycles per digit slot
//   HOLD_CYC : minimum SHOW cycles before a higher-priority takeover
// Optional macro SEGARB_RR_EN: once the hold expires, ownership rotates to
// the next asserted requester in cyclic order (lower indices included).
// ---------------------------------------------------------------------------
module seg_display_arbiter
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int HOLD_CYC = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_arbiter_if.slave  bus,
    output logic [7:0]            DIG,
    output logic [7:0]            Y
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);

    state_t             state_reg;
    state_t             state_next;
    logic [REQ_W-1:0]   owner_reg;
    logic [REQ_W-1:0]   owner_next;
    logic [NUM_REQ-1:0] gnt_reg;
    logic [NUM_REQ-1:0] gnt_next;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    logic [HOLD_W-1:0]  hold_cnt_next;
    logic [SEG_W-1:0]   seg_reg;
    logic [SEG_W-1:0]   seg_next;

    logic               scan_tick;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               load_zero;

    logic [REQ_W-1:0]   win;
    logic [REQ_W-1:0]   cand;
    logic               cand_valid;
    logic               owner_req;

    logic [BUS_W-1:0]   owner_seg;
    logic [SEG_W-1:0]   digit_arr [NUM_DIG];

    // ------------------------------------------------------------------
    // Slot timing. Outside SHOW every slot boundary re-arms the digit
    // index at 0, so the first SHOW slot after a blank is always digit 0.
    // ------------------------------------------------------------------
    assign load_zero = (state_reg != SHOW);
    assign next_idx  = IDX_W'(scan_idx + 1'b1);

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_zero (load_zero),
        .scan_tick (scan_tick),
        .scan_idx  (scan_idx)
    );

    // ------------------------------------------------------------------
    // Request decoding
    // ------------------------------------------------------------------
    assign win       = req_winner(bus.req);
    assign owner_req = bus.req[owner_reg];

`ifdef SEGARB_RR_EN
    // Rotate to the first asserted requester after the owner, wrapping.
    logic [REQ_W-1:0] rr_c1;
    logic [REQ_W-1:0] rr_c2;

    assign rr_c1 = rr_step(owner_reg);
    assign rr_c2 = rr_step(rr_c1);

    always_comb begin
        cand       = win;
        cand_valid = 1'b0;
        if (bus.req[rr_c1]) begin
            cand       = rr_c1;
            cand_valid = 1'b1;
        end else if (bus.req[rr_c2]) begin
            cand       = rr_c2;
            cand_valid = 1'b1;
        end
    end
`else
    // Only a strictly higher-priority requester may take over.
    assign cand       = win;
    assign cand_valid = (win > owner_reg);
`endif

    // ------------------------------------------------------------------
    // Owner's segment bus, split into per-digit patterns
    // ------------------------------------------------------------------
    always_comb begin
        unique case (owner_reg)
            2'd0:    owner_seg = bus.seg0;
            2'd1:    owner_seg = bus.seg1;
            default: owner_seg = bus.seg2;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_digit
            assign digit_arr[gi] = owner_seg[gi*SEG_W +: SEG_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbiter FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        gnt_next      = gnt_reg;
        hold_cnt_next = hold_cnt_reg;
        seg_next      = seg_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.req != '0) begin
                    owner_next    = win;
                    gnt_next      = req_onehot(win);
                    hold_cnt_next = '0;
                    state_next    = BLANK;
                end
            end

            BLANK: begin
                if (!owner_req) begin
                    // Owner gone: hand straight to the next winner, or idle.
                    hold_cnt_next = '0;
                    if (bus.req != '0) begin
                        owner_next = win;
                        gnt_next   = req_onehot(win);
                        state_next = BLANK;
                    end else begin
                        gnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if (scan_tick) begin
                    seg_next   = digit_arr[0];
                    state_next = SHOW;
                end
            end

            SHOW: begin
                if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_next = HOLD_W'(hold_cnt_reg + 1'b1);
                end
                // Ownership changes take precedence over a coincident
                // slot boundary; the new blank runs until the next tick.
                if (!owner_req) begin
                    hold_cnt_next = '0;
                    if (bus.req != '0) begin
                        owner_next = win;
                        gnt_next   = req_onehot(win);
                        state_next = BLANK;
                    end else begin
                        gnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if ((hold_cnt_reg == HOLD_MAX) && cand_valid) begin
                    owner_next    = cand;
                    gnt_next      = req_onehot(cand);
                    hold_cnt_next = '0;
                    state_next    = BLANK;
                end else if (scan_tick) begin
                    // Latch only at slot boundaries so bus edits never tear a slot.
                    seg_next = digit_arr[next_idx];
                end
            end

            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arbiter FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            gnt_reg      <= '0;
            hold_cnt_reg <= '0;
            seg_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            gnt_reg      <= gnt_next;
            hold_cnt_reg <= hold_cnt_next;
            seg_reg      <= seg_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only, so the pins never depend
    // combinationally on the request inputs.
    // ------------------------------------------------------------------
    assign bus.gnt  = gnt_reg;
    assign bus.busy = (state_reg != IDLE);

    generate
        for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_dig_pin
            assign DIG[gi] = ~((state_reg == SHOW) && (scan_idx == IDX_W'(gi)));
        end
    endgenerate

    assign Y = (state_reg == SHOW) ? {1'b1, ~seg_reg} : 8'hFF;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;
    import seg_display_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int HOLD_CYC = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_drv = 3'b000;
    logic [55:0] segv [3];
    logic [7:0]  dig;
    logic [7:0]  y;

    int n_checks = 0;
    int n_fail   = 0;

    seg_display_arbiter_if bus();

    assign bus.req  = req_drv;
    assign bus.seg0 = segv[0];
    assign bus.seg1 = segv[1];
    assign bus.seg2 = segv[2];

    seg_display_arbiter #(
        .SCAN_DIV (SCAN_DIV),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .DIG (dig),
        .Y   (y)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_owner;   // -1 = nobody owns the display
    bit         m_show;    // 1 while a digit is being lit
    int         m_digit;
    int         m_hold;
    int         m_div;
    logic [6:0] m_glyph;

    function automatic int highest(input logic [2:0] r);
        for (int i = 2; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int next_owner(input logic [2:0] r, input int cur);
`ifdef SEGARB_RR_EN
        for (int d = 1; d < 3; d++) begin
            if (r[(cur + d) % 3]) return (cur + d) % 3;
        end
        return -1;
`else
        int w;
        w = highest(r);
        return (w > cur) ? w : -1;
`endif
    endfunction

    function automatic logic [6:0] glyph_of(input int who, input int k);
        logic [55:0] s;
        s = segv[who];
        return s[7*k +: 7];
    endfunction

    function void m_reset();
        m_owner = -1;
        m_show  = 1'b0;
        m_digit = 0;
        m_hold  = 0;
        m_div   = 0;
        m_glyph = 7'd0;
    endfunction

    function void m_step(input logic rst_s, input logic [2:0] r);
        bit tick;
        int nxt;
        if (rst_s) begin
            m_reset();
            return;
        end
        tick  = (m_div == SCAN_DIV - 1);
        m_div = (m_div + 1) % SCAN_DIV;
        if (m_owner < 0 || !r[m_owner]) begin
            m_owner = highest(r);
            m_show  = 1'b0;
            m_hold  = 0;
        end else if (!m_show) begin
            if (tick) begin
                m_show  = 1'b1;
                m_digit = 0;
                m_glyph = glyph_of(m_owner, 0);
            end
        end else begin
            nxt = next_owner(r, m_owner);
            if (m_hold == HOLD_CYC && nxt >= 0) begin
                m_owner = nxt;
                m_show  = 1'b0;
                m_hold  = 0;
            end else begin
                if (m_hold < HOLD_CYC) m_hold++;
                if (tick) begin
                    m_digit = (m_digit + 1) % 8;
                    m_glyph = glyph_of(m_owner, m_digit);
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic [2:0] r);
        rst     = 1'b1;
        req_drv = r;
        step_clk();
        step_clk();
        check("rst_gnt",  32'(bus.gnt),  32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_dig",  32'(dig),      32'hFF);
        check("rst_y",    32'(y),        32'hFF);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic wait_show(input int limit, output int n);
        n = 0;
        while (dig === 8'hFF && n < limit) begin
            step_clk();
            n++;
        end
    endtask

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic       busy;
        int         lat;
        logic [7:0] dig;
        logic [7:0] y;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n;
        logic [2:0] rr_req;
        logic [2:0] exp_gnt;
        logic [7:0] exp_dig;
        logic [7:0] exp_y;

        segv[0] = {GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, 7'b1001111, GLYPH_2, GLYPH_1, GLYPH_L};
        segv[1] = {{7{GLYPH_0}}, GLYPH_D};
        segv[2] = {{7{GLYPH_8}}, GLYPH_9};

        // Grant from IDLE and first lit digit, per request pattern
        vecs[0] = '{req: 3'b000, gnt: 3'b000, busy: 1'b0, lat: 12, dig: 8'hFF, y: 8'hFF};
        vecs[1] = '{req: 3'b001, gnt: 3'b001, busy: 1'b1, lat: 3,  dig: 8'hFE, y: 8'hC7};
        vecs[2] = '{req: 3'b010, gnt: 3'b010, busy: 1'b1, lat: 3,  dig: 8'hFE, y: 8'hA1};
        vecs[3] = '{req: 3'b011, gnt: 3'b010, busy: 1'b1, lat: 3,  dig: 8'hFE, y: 8'hA1};
        vecs[4] = '{req: 3'b100, gnt: 3'b100, busy: 1'b1, lat: 3,  dig: 8'hFE, y: 8'h98};
        vecs[5] = '{req: 3'b101, gnt: 3'b100, busy: 1'b1, lat: 3,  dig: 8'hFE, y: 8'h98};
        vecs[6] = '{req: 3'b110, gnt: 3'b100, busy: 1'b1, lat: 3,  dig: 8'hFE, y: 8'h98};
        vecs[7] = '{req: 3'b111, gnt: 3'b100, busy: 1'b1, lat: 3,  dig: 8'hFE, y: 8'h98};

        for (int i = 0; i < 8; i++) begin
            do_reset(vecs[i].req);
            step_clk();
            check("vec_gnt",   32'(bus.gnt),  32'(vecs[i].gnt));
            check("vec_busy",  32'(bus.busy), 32'(vecs[i].busy));
            check("vec_blank", 32'(dig),      32'hFF);
            wait_show(12, n);
            check("vec_lat", 32'(n),   32'(vecs[i].lat));
            check("vec_dig", 32'(dig), 32'(vecs[i].dig));
            check("vec_y",   32'(y),   32'(vecs[i].y));
            $display("vector %0d req=%b done", i, vecs[i].req);
        end

        // Scan order: digits 0..7 contiguous, 4 cycles each, wrapping to 0
        do_reset(3'b001);
        wait_show(12, n);
        for (int s = 0; s < 9; s++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                exp_dig = 8'hFF ^ (8'h01 << (s % 8));
                check("scan_dig", 32'(dig), 32'(exp_dig));
                if (s == 3 && c == 0) check("scan_y_digit3", 32'(y), 32'hB0);
                step_clk();
            end
        end
        $display("scan order sequence done");

        // Preemption waits for the hold time
        do_reset(3'b001);
        wait_show(12, n);
        repeat (5) step_clk();
        req_drv = 3'b101;
        n = 0;
        while (bus.gnt !== 3'b100 && n < 40) begin
            check("preempt_hold_gnt", 32'(bus.gnt), 32'h1);
            step_clk();
            n++;
        end
        check("preempt_delay", 32'(n), 32'd16);
        check("preempt_blank", 32'(dig), 32'hFF);
        wait_show(12, n);
        check("preempt_dig", 32'(dig), 32'hFE);
        check("preempt_y",   32'(y),   32'h98);
        $display("preemption sequence done");

        // Lower-priority request after hold expiry
        for (int k = 0; k < 2; k++) begin
            rr_req = (k == 0) ? 3'b110 : 3'b111;
            do_reset(3'b100);
            wait_show(12, n);
            repeat (25) step_clk();
            req_drv = rr_req;
            repeat (6) step_clk();
`ifdef SEGARB_RR_EN
            exp_gnt = (k == 0) ? 3'b010 : 3'b001;
`else
            exp_gnt = 3'b100;
`endif
            check("low_prio_gnt", 32'(bus.gnt), 32'(exp_gnt));
            $display("low priority sequence req=%b done", rr_req);
        end

        // Owner drop with a pending request, then full release
        do_reset(3'b001);
        wait_show(12, n);
        repeat (3) step_clk();
        req_drv = 3'b010;
        step_clk();
        check("handover_gnt",  32'(bus.gnt),  32'h2);
        check("handover_busy", 32'(bus.busy), 32'h1);
        check("handover_dig",  32'(dig),      32'hFF);
        req_drv = 3'b000;
        step_clk();
        check("release_gnt",  32'(bus.gnt),  32'h0);
        check("release_busy", 32'(bus.busy), 32'h0);
        check("release_dig",  32'(dig),      32'hFF);
        $display("handover sequence done");

        // Reset mid-SHOW on a slot boundary
        do_reset(3'b001);
        wait_show(12, n);
        repeat (11) step_clk();
        check("midrst_pre_dig",  32'(dig),           32'hFB);
        check("midrst_pre_tick", 32'(dut.scan_tick), 32'h1);
        rst = 1'b1;
        step_clk();
        check("midrst_gnt",  32'(bus.gnt),      32'h0);
        check("midrst_busy", 32'(bus.busy),     32'h0);
        check("midrst_dig",  32'(dig),          32'hFF);
        check("midrst_y",    32'(y),            32'hFF);
        check("midrst_idx",  32'(dut.scan_idx), 32'h0);
        rst = 1'b0;
        wait_show(12, n);
        check("midrst_restart_dig", 32'(dig), 32'hFE);
        $display("mid-operation reset sequence done");

        // Randomized run against the reference model
        do_reset(3'b000);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) req_drv = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                if (i != m_owner && $urandom_range(0, 19) == 0) segv[i] = 56'({$urandom(), $urandom()});
            end
            step_clk();
            m_step(rst, req_drv);
            exp_gnt = (m_owner >= 0) ? 3'(3'b001 << m_owner) : 3'b000;
            exp_dig = m_show ? ~(8'h01 << m_digit) : 8'hFF;
            exp_y   = m_show ? {1'b1, ~m_glyph} : 8'hFF;
            check("random", {12'd0, bus.gnt, bus.busy, dig, y},
                  {12'd0, exp_gnt, (m_owner >= 0), exp_dig, exp_y});
        end
        $display("random sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
